// File: rtl/lbus_rx_buffer.sv
// LBUS sink endpoint: buffers 4-segment LBUS words in a FWFT FIFO, forwards them
// unchanged on a valid/ready stream, and checks per-segment packet framing.
module lbus_rx_buffer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int RDY_LATENCY = 4
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic [511:0] RX_DATA,
    input  logic [3:0]   RX_ENA,
    input  logic [3:0]   RX_SOP,
    input  logic [3:0]   RX_EOP,
    input  logic [3:0]   RX_ERR,
    input  logic [15:0]  RX_MTY,
    output logic         RX_RDY,
    output logic [511:0] TX_DATA,
    output logic [3:0]   TX_ENA,
    output logic [3:0]   TX_SOP,
    output logic [3:0]   TX_EOP,
    output logic [3:0]   TX_ERR,
    output logic [15:0]  TX_MTY,
    output logic         TX_VLD,
    input  logic         TX_DST_RDY,
    output logic         PROTO_ERR,
    output logic         OVERFLOW,
    output logic [31:0]  PKT_CNT,
    output logic [15:0]  DROP_CNT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [511:0] data;
        logic [3:0]   ena;
        logic [3:0]   sop;
        logic [3:0]   eop;
        logic [3:0]   err;
        logic [15:0]  mty;
    } word_t;

    typedef enum logic {IDLE, IN_PKT} frame_t;

    word_t         mem [FIFO_DEPTH];
    word_t         wr_word, head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          valid_in, full, push, pop, drop;
    frame_t        state, state_nxt, st;
    logic          viol;

    assign valid_in  = |RX_ENA;
    assign full      = (count == CW'(FIFO_DEPTH));
    assign TX_VLD    = (count != '0);
    assign pop       = TX_VLD & TX_DST_RDY;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = valid_in & (~full | pop);
    assign drop      = valid_in & ~push;
    assign count_nxt = count + CW'(push) - CW'(pop);

    assign wr_word = '{data: RX_DATA, ena: RX_ENA, sop: RX_SOP, eop: RX_EOP,
                       err: RX_ERR, mty: RX_MTY};
    assign head    = mem[rd_ptr];
    assign TX_DATA = head.data;
    assign TX_ENA  = head.ena;
    assign TX_SOP  = head.sop;
    assign TX_EOP  = head.eop;
    assign TX_ERR  = head.err;
    assign TX_MTY  = head.mty;

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            RX_RDY    <= 1'b0;
            OVERFLOW  <= 1'b0;
            PROTO_ERR <= 1'b0;
            PKT_CNT   <= '0;
            DROP_CNT  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_nxt;
            RX_RDY    <= (CW'(FIFO_DEPTH) - count_nxt) > CW'(RDY_LATENCY);
            OVERFLOW  <= drop;
            PROTO_ERR <= push & viol;
            if (push) PKT_CNT <= PKT_CNT + 32'($countones(RX_EOP & RX_ENA));
            if (drop && DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Segments walked in order; state follows SOP/EOP even when a violation is flagged.
    always_comb begin
        st   = state;
        viol = !(RX_ENA inside {4'b0001, 4'b0011, 4'b0111, 4'b1111});
        for (int s = 0; s < 4; s++) begin
            if (!RX_ENA[s]) begin
                if (RX_SOP[s] || RX_EOP[s]) viol = 1'b1;
            end else begin
                if (RX_SOP[s]) begin
                    if (st == IN_PKT) viol = 1'b1;
                    st = IN_PKT;
                end else if (st == IDLE) begin
                    viol = 1'b1;
                end
                if (RX_EOP[s]) st = IDLE;
                else if (RX_ERR[s] || RX_MTY[s*4 +: 4] != 4'd0) viol = 1'b1;
            end
        end
        state_nxt = push ? st : state;
    end
endmodule

// File: tb/tb_lbus_rx_buffer.sv
// Directed bench for lbus_rx_buffer: reset, latency, backpressure/overflow,
// full pop+push, framing violations and mid-packet reset.
module tb_lbus_rx_buffer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] rx_data;
    logic [3:0]   rx_ena, rx_sop, rx_eop, rx_err;
    logic [15:0]  rx_mty;
    logic         rx_rdy;
    logic [511:0] tx_data;
    logic [3:0]   tx_ena, tx_sop, tx_eop, tx_err;
    logic [15:0]  tx_mty;
    logic         tx_vld, tx_dst_rdy;
    logic         proto_err, overflow;
    logic [31:0]  pkt_cnt;
    logic [15:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lbus_rx_buffer #(.FIFO_DEPTH(16), .RDY_LATENCY(4)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .RX_DATA(rx_data), .RX_ENA(rx_ena), .RX_SOP(rx_sop), .RX_EOP(rx_eop),
        .RX_ERR(rx_err), .RX_MTY(rx_mty), .RX_RDY(rx_rdy),
        .TX_DATA(tx_data), .TX_ENA(tx_ena), .TX_SOP(tx_sop), .TX_EOP(tx_eop),
        .TX_ERR(tx_err), .TX_MTY(tx_mty), .TX_VLD(tx_vld), .TX_DST_RDY(tx_dst_rdy),
        .PROTO_ERR(proto_err), .OVERFLOW(overflow),
        .PKT_CNT(pkt_cnt), .DROP_CNT(drop_cnt)
    );

    function automatic logic [511:0] wdata(input int i);
        return {16{32'(i) ^ 32'hA5000000}};
    endfunction

    task automatic chk(input string tag, input logic [543:0] got, input logic [543:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] ena, input logic [3:0] sop, input logic [3:0] eop,
                        input logic [15:0] mty, input logic [511:0] d);
        rx_ena = ena; rx_sop = sop; rx_eop = eop; rx_err = 4'd0; rx_mty = mty; rx_data = d;
        tick();
    endtask

    task automatic idle();
        send(4'd0, 4'd0, 4'd0, 16'd0, '0);
    endtask

    initial begin
        rst_n = 1'b0; tx_dst_rdy = 1'b1;
        rx_ena = 0; rx_sop = 0; rx_eop = 0; rx_err = 0; rx_mty = 0; rx_data = '0;
        #12;
        chk("rst_rdy", 544'(rx_rdy), 544'(0));
        chk("rst_vld", 544'(tx_vld), 544'(0));
        chk("rst_perr", 544'(proto_err), 544'(0));
        chk("rst_ovf", 544'(overflow), 544'(0));
        chk("rst_pkt", 544'(pkt_cnt), 544'(0));
        chk("rst_drop", 544'(drop_cnt), 544'(0));
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", 544'(rx_rdy), 544'(1));

        // 1: single-segment packet, one-cycle latency, bit-exact copy
        send(4'b0001, 4'b0001, 4'b0001, 16'h0005, wdata(100));
        chk("t1_vld", 544'(tx_vld), 544'(1));
        chk("t1_data", 544'(tx_data), 544'(wdata(100)));
        chk("t1_ctrl", 544'({tx_ena, tx_sop, tx_eop, tx_err, tx_mty}),
            544'({4'b0001, 4'b0001, 4'b0001, 4'b0000, 16'h0005}));
        chk("t1_pkt", 544'(pkt_cnt), 544'(1));
        chk("t1_perr", 544'(proto_err), 544'(0));
        idle();
        chk("t1_drained", 544'(tx_vld), 544'(0));

        // 2: backpressure; RDY drops after 12th write, 17th word dropped
        tx_dst_rdy = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            send(4'b1111, 4'b0001, 4'b1000, 16'h2000, wdata(i));
            if (i == 11) chk("t2_rdy_11", 544'(rx_rdy), 544'(1));
            if (i == 12) chk("t2_rdy_12", 544'(rx_rdy), 544'(0));
        end
        chk("t2_no_ovf", 544'(overflow), 544'(0));
        send(4'b1111, 4'b0001, 4'b1000, 16'h0000, wdata(17));
        chk("t2_ovf", 544'(overflow), 544'(1));
        chk("t2_drop", 544'(drop_cnt), 544'(1));
        chk("t2_pkt", 544'(pkt_cnt), 544'(17));
        chk("t2_head", 544'(tx_data), 544'(wdata(1)));

        // 3: full FIFO with simultaneous pop and push
        tx_dst_rdy = 1'b1;
        send(4'b1111, 4'b0001, 4'b1000, 16'h0000, wdata(18));
        chk("t3_no_ovf", 544'(overflow), 544'(0));
        chk("t3_drop", 544'(drop_cnt), 544'(1));
        chk("t3_rdy", 544'(rx_rdy), 544'(0));
        chk("t3_pkt", 544'(pkt_cnt), 544'(18));
        for (int k = 2; k <= 17; k++) begin
            chk("t3_order_vld", 544'(tx_vld), 544'(1));
            chk("t3_order", 544'(tx_data), 544'(wdata(k == 17 ? 18 : k)));
            idle();
        end
        chk("t3_empty", 544'(tx_vld), 544'(0));
        chk("t3_ovf_pulse", 544'(overflow), 544'(0));

        // 4: two packets in one word, then an illegal ENA pattern
        send(4'b1111, 4'b0101, 4'b1010, 16'h0000, wdata(40));
        chk("t4_pkt", 544'(pkt_cnt), 544'(20));
        chk("t4_ok", 544'(proto_err), 544'(0));
        send(4'b0101, 4'b0001, 4'b0100, 16'h0000, wdata(41));
        chk("t4_ena_err", 544'(proto_err), 544'(1));
        chk("t4_pkt2", 544'(pkt_cnt), 544'(21));
        idle();
        chk("t4_pulse", 544'(proto_err), 544'(0));

        // 5: SOP while in packet, MTY on non-EOP segment
        send(4'b0001, 4'b0001, 4'b0000, 16'h0000, wdata(50));
        chk("t5_open", 544'(proto_err), 544'(0));
        send(4'b0001, 4'b0001, 4'b0000, 16'h0000, wdata(51));
        chk("t5_dup_sop", 544'(proto_err), 544'(1));
        send(4'b0001, 4'b0000, 4'b0000, 16'h0003, wdata(52));
        chk("t5_mty", 544'(proto_err), 544'(1));
        send(4'b0001, 4'b0000, 4'b0001, 16'h0000, wdata(53));
        chk("t5_close", 544'(proto_err), 544'(0));
        chk("t5_pkt", 544'(pkt_cnt), 544'(22));
        idle();

        // 6: reset mid-packet with 5 words buffered
        tx_dst_rdy = 1'b0;
        send(4'b1111, 4'b0001, 4'b0000, 16'h0000, wdata(60));
        for (int i = 61; i <= 64; i++) send(4'b1111, 4'b0000, 4'b0000, 16'h0000, wdata(i));
        chk("t6_buffered", 544'(tx_vld), 544'(1));
        rx_ena = 4'd0; rx_sop = 4'd0; rx_eop = 4'd0;
        rst_n = 1'b0;
        #1;
        chk("t6_vld", 544'(tx_vld), 544'(0));
        chk("t6_rdy", 544'(rx_rdy), 544'(0));
        chk("t6_pkt", 544'(pkt_cnt), 544'(0));
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("t6_rdy_back", 544'(rx_rdy), 544'(1));
        tx_dst_rdy = 1'b1;
        send(4'b0001, 4'b0000, 4'b0000, 16'h0000, wdata(70));
        chk("t6_nosop_err", 544'(proto_err), 544'(1));
        chk("t6_new_head", 544'(tx_data), 544'(wdata(70)));
        idle();
        chk("t6_empty", 544'(tx_vld), 544'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
